serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, bit-serial successor to the combinational half adder.
- Adds two WIDTH-bit operands plus carry-in using one full-adder cell and a carry flip-flop, processing one bit per clock, LSB first.
- Uses a start/busy/done handshake. Intended for small-area arithmetic in the toys RTL set and as a stimulus target for sequential benches.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result bits; held until the next completion
- carry  output  1  carry-out; held until the next completion

Behaviour:
- Reset (async, active-high), applied immediately regardless of clk:
  - state=IDLE, busy=0, done=0, sum=0, carry=0.
  - Internal shift registers, carry flop and bit counter are cleared.
- States: IDLE, RUN. The counter cnt is max(1,$clog2(WIDTH)) bits wide.
- IDLE:
  - On an edge with start=1: capture a, b into shift regs A_sh, B_sh; c<=cin; cnt<=0; state<=RUN; busy<=1.
  - done<=0 on every edge in IDLE.
  - start=0: remain IDLE.
- RUN, each edge:
  - s = A_sh[0]^B_sh[0]^c.
  - c <= (A_sh[0]&B_sh[0]) | (c&(A_sh[0]^B_sh[0])).
  - A_sh, B_sh shift right by one.
  - s shifts into MSB of the partial register P, which shifts right.
  - cnt<=cnt+1.
- RUN, last bit (cnt==WIDTH-1):
  - sum<=final P (including this bit); carry<=carry-out of this bit.
  - done<=1; busy<=0; state<=IDLE.
- Latency: start accepted at edge k means done=1 and sum/carry valid after edge k+WIDTH, for exactly one cycle.
- sum/carry change only on completion edges and reset. Partial results are never visible.
- start while busy=1 is ignored and not queued. a, b and cin may change freely during RUN.
- Back-to-back: start=1 in the cycle where done=1 (state is IDLE) is accepted at the next edge. done drops on that edge, and sum/carry hold the previous result until the new completion.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1:
  - Completes one edge after acceptance.
  - With cin=0, sum/carry equal the half-adder truth table.
- Reset asserted mid-RUN: the operation is aborted, all outputs and state return to reset values, and no done pulse is produced.
- Reset deasserted with start=1 already high: accepted on the first clock edge after deassertion.

Test Plan:
- WIDTH=4: a=5, b=3, cin=0, 1-cycle start pulse -> busy=1 for 4 cycles, then done=1 for 1 cycle with sum=8, carry=0; sum stays 0 until that edge.
- WIDTH=4: a=15, b=1, cin=0 -> sum=0, carry=1. Then a=15, b=15, cin=1 -> sum=15, carry=1.
- WIDTH=1: sweep {a,b}=00,01,10,11 with cin=0 -> (sum,carry) = (0,0), (1,0), (1,0), (0,1); each done arrives 1 cycle after acceptance.
- WIDTH=8: start held high continuously with a=200, b=100, cin=0 and a changed to 0 during RUN -> done every 9th cycle with sum=44, carry=1 (first result uses captured a=200). Extra start pulses while busy produce no extra done.
- WIDTH=8: assert rst between clock edges on the 3rd RUN cycle -> busy, done, sum and carry go to 0 immediately without a clock edge, and no done pulse follows. After release, a fresh start of a=1, b=1 -> sum=2.
- Randomised self-check against a + b + cin for WIDTH in {1, 4, 8, 16}, 1000 vectors each, with random start gaps including back-to-back starts on done cycles.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add WIDTH-bit operands
// LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] p_next;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s;
  logic             c_next;

  always_comb begin
    s      = a_sh[0] ^ b_sh[0] ^ c;
    c_next = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
  end

  // The new sum bit enters at the MSB so that after WIDTH shifts the
  // partial register holds the result in natural bit order.
  generate
    if (WIDTH == 1) begin : g_p1
      assign p_next = s;
    end else begin : g_pn
      assign p_next = {s, p[WIDTH-1:1]};
    end
  endgenerate

  // sum/carry are only loaded on the completion edge, so partial results
  // never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      p     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_next;
          p    <= p_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= p_next;
            carry <= c_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder at WIDTH 1, 4, 8 and 16,
// compared against plain integer addition.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  startVec;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic        cinIn;
  logic [3:0]  busyV;
  logic [3:0]  doneV;
  logic [3:0]  carryV;
  logic [0:0]  sum1;
  logic [3:0]  sum4;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  int          sel;
  int          widths[4] = '{1, 4, 8, 16};
  int          prevRes[4];
  int          checkCount = 0;
  int          passCount = 0;
  logic        busyM;
  logic        doneM;
  logic        carryM;
  logic [15:0] sumM;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(startVec[0]), .a(aIn[0:0]), .b(bIn[0:0]), .cin(cinIn),
    .busy(busyV[0]), .done(doneV[0]), .sum(sum1), .carry(carryV[0]));
  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(startVec[1]), .a(aIn[3:0]), .b(bIn[3:0]), .cin(cinIn),
    .busy(busyV[1]), .done(doneV[1]), .sum(sum4), .carry(carryV[1]));
  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(startVec[2]), .a(aIn[7:0]), .b(bIn[7:0]), .cin(cinIn),
    .busy(busyV[2]), .done(doneV[2]), .sum(sum8), .carry(carryV[2]));
  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(startVec[3]), .a(aIn), .b(bIn), .cin(cinIn),
    .busy(busyV[3]), .done(doneV[3]), .sum(sum16), .carry(carryV[3]));

  // Route the selected instance's outputs onto one set of observation signals.
  always_comb begin
    sumM   = 16'd0;
    busyM  = busyV[sel];
    doneM  = doneV[sel];
    carryM = carryV[sel];
    case (sel)
      0:       sumM = {15'd0, sum1};
      1:       sumM = {12'd0, sum4};
      2:       sumM = {8'd0, sum8};
      default: sumM = sum16;
    endcase
  end

  function automatic int obsRes();
    return (int'(carryM) << widths[sel]) | int'(sumM);
  endfunction

  function automatic int modelAdd(input int w, input int av, input int bv, input int ci);
    int ma;
    ma = (1 << w) - 1;
    return ((av & ma) + (bv & ma) + ci) & ((1 << (w + 1)) - 1);
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One full operation, entered at a negedge with the selected adder idle
  // (possibly on its done cycle, which exercises back-to-back acceptance).
  task automatic applyStimulus(input int s, input logic [15:0] av, input logic [15:0] bv,
                               input logic ci);
    int w;
    int exp;
    int edges;
    bit held;
    w   = widths[s];
    sel = s;
    aIn = av;
    bIn = bv;
    cinIn = ci;
    exp = modelAdd(w, int'(av), int'(bv), int'(ci));
    startVec = 4'b0;
    startVec[s] = 1'b1;
    @(negedge clk);
    startVec = 4'b0;
    aIn = 16'($urandom);
    bIn = 16'($urandom);
    cinIn = 1'($urandom);
    checkOutput("busy_after_accept", int'(busyM), 1);
    checkOutput("done_cleared", int'(doneM), 0);
    held  = 1'b1;
    edges = 0;
    while (!doneM && edges < w + 4) begin
      if (obsRes() != prevRes[s]) held = 1'b0;
      @(negedge clk);
      edges++;
    end
    checkOutput("latency", edges, w);
    checkOutput("result_held", int'(held), 1);
    checkOutput("result", obsRes(), exp);
    checkOutput("busy_at_done", int'(busyM), 0);
    prevRes[s] = exp;
  endtask

  initial begin
    int doneCount;
    int firstAt;
    int secondAt;
    int gap;
    bit noDone;

    rst = 1'b1;
    startVec = 4'b0;
    aIn = 16'd0;
    bIn = 16'd0;
    cinIn = 1'b0;
    sel = 0;
    for (int i = 0; i < 4; i++) prevRes[i] = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      checkOutput("reset_busy", int'(busyM), 0);
      checkOutput("reset_done", int'(doneM), 0);
      checkOutput("reset_result", obsRes(), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=4 directed cases
    applyStimulus(1, 16'd5, 16'd3, 1'b0);
    applyStimulus(1, 16'd15, 16'd1, 1'b0);
    applyStimulus(1, 16'd15, 16'd15, 1'b1);

    // WIDTH=1 half-adder sweep
    for (int v = 0; v < 4; v++) applyStimulus(0, 16'(v >> 1), 16'(v & 1), 1'b0);

    // WIDTH=8 with start held high and operand A changed during RUN
    @(negedge clk);
    sel = 2;
    aIn = 16'd200;
    bIn = 16'd100;
    cinIn = 1'b0;
    startVec = 4'b0100;
    @(negedge clk);
    aIn = 16'd0;
    doneCount = 0;
    firstAt = 0;
    secondAt = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (doneM) begin
        doneCount++;
        if (doneCount == 1) begin
          firstAt = i;
          checkOutput("held_start_first", obsRes(), modelAdd(8, 200, 100, 0));
        end else if (doneCount == 2) begin
          secondAt = i;
          checkOutput("held_start_second", obsRes(), modelAdd(8, 0, 100, 0));
        end
      end
      if (i == 17) startVec = 4'b0;
    end
    checkOutput("held_start_done_count", doneCount, 2);
    checkOutput("held_start_first_at", firstAt, 8);
    checkOutput("held_start_second_at", secondAt, 17);
    prevRes[2] = modelAdd(8, 0, 100, 0);

    // Asynchronous reset in the middle of a WIDTH=8 addition
    @(negedge clk);
    aIn = 16'd7;
    bIn = 16'd9;
    startVec = 4'b0100;
    @(negedge clk);
    startVec = 4'b0;
    repeat (2) @(negedge clk);
    checkOutput("busy_before_abort", int'(busyM), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busyM), 0);
    checkOutput("abort_done", int'(doneM), 0);
    checkOutput("abort_result", obsRes(), 0);
    for (int i = 0; i < 4; i++) prevRes[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    noDone = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (doneM || busyM) noDone = 1'b0;
    end
    checkOutput("no_done_after_abort", int'(noDone), 1);
    applyStimulus(2, 16'd1, 16'd1, 1'b0);

    // Reset released while start is already high
    rst = 1'b1;
    for (int i = 0; i < 4; i++) prevRes[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2, 16'd1, 16'd1, 1'b0);

    // Randomised vectors with random gaps, including back-to-back starts
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 1000; n++) begin
        applyStimulus(s, 16'($urandom), 16'($urandom), 1'($urandom));
        gap = int'($urandom_range(0, 3));
        repeat (gap) @(negedge clk);
        if (gap > 0) checkOutput("done_one_cycle", int'(doneM), 0);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
